// File: rtl/lfu_victim_selector.sv
// lfu_victim_selector
//   Scans the entries 0..NUM_ENTRIES-1 of an external LFU counter block and returns the
//   address and count of the least-frequently-used entry. Ties go to the lowest address.
//   One address is issued per cycle. The count comes back one cycle later and is compared
//   against a running minimum.
//
// Ports
//   clk            sole clock, rising edge
//   gen_reset      synchronous active-high reset
//   req            start a search (accepted only while idle)
//   busy           search in progress; req is ignored while high
//   done           one-cycle pulse; victim_* is valid and updated in this cycle
//   adress         entry address driven to the counter block
//   count_read     read strobe to the counter block
//   count_in       counter block output, valid one cycle after adress/count_read
//   victim_adress  address of the least-frequently-used entry (held until next done)
//   victim_count   count of that entry
//
// Configuration
//   LFU_EARLY_EXIT_EN  when defined, a compared count of zero ends the search at once.
//                      A zero can never be beaten, so nothing further can change the result.

module lfu_victim_selector #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned COUNT_W     = 4,
   parameter int unsigned NUM_ENTRIES = 1024
) (
   input  logic               clk,
   input  logic               gen_reset,
   input  logic               req,
   output logic               busy,
   output logic               done,
   output logic [ADDR_W-1:0]  adress,
   output logic               count_read,
   input  logic [COUNT_W-1:0] count_in,
   output logic [ADDR_W-1:0]  victim_adress,
   output logic [COUNT_W-1:0] victim_count
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_ENTRIES - 1);

   typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

   state_e               state_q;
   logic                 busy_q;
   logic                 done_q;
   logic [ADDR_W-1:0]    adress_q;
   logic                 count_read_q;
   logic [ADDR_W-1:0]    victim_adress_q;
   logic [COUNT_W-1:0]   victim_count_q;

   // Compare pipeline: pend_q marks that count_in carries the entry at pend_addr_q.
   logic                 pend_q;
   logic [ADDR_W-1:0]    pend_addr_q;
   logic [COUNT_W-1:0]   min_cnt_q, min_cnt_d;
   logic [ADDR_W-1:0]    min_addr_q, min_addr_d;
   logic                 take;
   logic                 early_exit;

   assign busy          = busy_q;
   assign done          = done_q;
   assign adress        = adress_q;
   assign count_read    = count_read_q;
   assign victim_adress = victim_adress_q;
   assign victim_count  = victim_count_q;

   // The scan always starts at address 0, so the entry at address 0 is the first one compared.
   // That entry loads the minimum unconditionally. After that, only a strictly smaller count
   // replaces it, which keeps the lower address on a tie.
   always_comb begin
      take       = pend_q && ((pend_addr_q == '0) || (count_in < min_cnt_q));
      min_cnt_d  = take ? count_in    : min_cnt_q;
      min_addr_d = take ? pend_addr_q : min_addr_q;
`ifdef LFU_EARLY_EXIT_EN
      early_exit = pend_q && (count_in == '0);
`else
      early_exit = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (gen_reset) begin
         state_q         <= StIdle;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         adress_q        <= '0;
         count_read_q    <= 1'b0;
         victim_adress_q <= '0;
         victim_count_q  <= '0;
         pend_q          <= 1'b0;
         pend_addr_q     <= '0;
         min_cnt_q       <= '0;
         min_addr_q      <= '0;
      end else begin
         // After an early exit, the address issued in the same cycle is discarded.
         pend_q      <= count_read_q && !early_exit;
         pend_addr_q <= adress_q;
         min_cnt_q   <= min_cnt_d;
         min_addr_q  <= min_addr_d;

         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (req) begin
                  state_q      <= StScan;
                  busy_q       <= 1'b1;
                  adress_q     <= '0;
                  count_read_q <= 1'b1;
                  min_cnt_q    <= '0;
                  min_addr_q   <= '0;
               end
            end
            StScan: begin
               if (early_exit) begin
                  state_q         <= StDone;
                  count_read_q    <= 1'b0;
                  done_q          <= 1'b1;
                  victim_adress_q <= min_addr_d;
                  victim_count_q  <= min_cnt_d;
               end else if (adress_q == LastAddr) begin
                  state_q      <= StDrain;
                  count_read_q <= 1'b0;
               end else begin
                  adress_q <= adress_q + 1'b1;
               end
            end
            StDrain: begin
               // The last entry is compared here.
               state_q         <= StDone;
               done_q          <= 1'b1;
               victim_adress_q <= min_addr_d;
               victim_count_q  <= min_cnt_d;
            end
            StDone: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q      <= StIdle;
               busy_q       <= 1'b0;
               done_q       <= 1'b0;
               count_read_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lfu_victim_selector.sv
module tb_lfu_victim_selector;

   localparam int AW = 4;
   localparam int CW = 4;
   localparam int N  = 8;

   logic          clk = 1'b0;
   logic          gen_reset;
   logic          req;
   logic          busy;
   logic          done;
   logic [AW-1:0] adress;
   logic          count_read;
   logic [CW-1:0] count_in;
   logic [AW-1:0] victim_adress;
   logic [CW-1:0] victim_count;

   int errors = 0;
   int checks = 0;

   logic [CW-1:0] mem [16];

   lfu_victim_selector #(
      .ADDR_W      (AW),
      .COUNT_W     (CW),
      .NUM_ENTRIES (N)
   ) dut (
      .clk           (clk),
      .gen_reset     (gen_reset),
      .req           (req),
      .busy          (busy),
      .done          (done),
      .adress        (adress),
      .count_read    (count_read),
      .count_in      (count_in),
      .victim_adress (victim_adress),
      .victim_count  (victim_count)
   );

   always #5 clk = ~clk;

   // Counter block: returns the count one cycle after a read, and junk otherwise.
   always @(posedge clk) begin
      if (count_read) count_in <= mem[adress];
      else            count_in <= CW'($urandom());
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a search is a timeline relative to the accepted request.
   bit            m_valid  = 1'b0;
   bit            m_active = 1'b0;
   int            m_k, m_stop, m_last;
   logic [AW-1:0] m_va;
   logic [CW-1:0] m_vc;
   logic          e_busy, e_done, e_rd;
   logic [AW-1:0] e_adr, e_va;
   logic [CW-1:0] e_vc;

   task automatic plan();
      bit found;
      m_va   = '0;
      m_vc   = mem[0];
      for (int j = 1; j < N; j++) begin
         if (mem[j] < m_vc) begin
            m_va = AW'(j);
            m_vc = mem[j];
         end
      end
      m_stop = N + 2;
      m_last = N;
`ifdef LFU_EARLY_EXIT_EN
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
         if (!found && mem[j] == '0) begin
            found  = 1'b1;
            m_va   = AW'(j);
            m_vc   = '0;
            m_stop = j + 3;
            m_last = (j + 2 < N) ? j + 2 : N;
         end
      end
`else
      found = 1'b0;
`endif
   endtask

   always @(posedge clk) begin
      if (gen_reset) begin
         m_valid  = 1'b1;
         m_active = 1'b0;
         m_k      = 0;
         e_adr    = '0;
         e_va     = '0;
         e_vc     = '0;
      end else if (m_valid) begin
         if (!m_active) begin
            if (req) begin
               plan();
               m_active = 1'b1;
               m_k      = 1;
            end
         end else if (m_k == m_stop) begin
            m_active = 1'b0;
         end else begin
            m_k++;
         end
      end
      e_busy = m_active;
      e_done = m_active && (m_k == m_stop);
      e_rd   = m_active && (m_k <= m_last);
      if (e_rd) e_adr = AW'(m_k - 1);
      if (e_done) begin
         e_va = m_va;
         e_vc = m_vc;
      end
   end

   always @(posedge clk) begin
      #1;
      if (m_valid) begin
         chk("busy",          busy,          e_busy);
         chk("done",          done,          e_done);
         chk("count_read",    count_read,    e_rd);
         chk("adress",        adress,        e_adr);
         chk("victim_adress", victim_adress, e_va);
         chk("victim_count",  victim_count,  e_vc);
      end
   end

   task automatic load(input logic [31:0] v);
      for (int j = 0; j < N; j++) mem[j] = v[4*j +: 4];
   endtask

   // Issues req, then watches 16 cycles. Cycle T+n follows the n-th edge.
   task automatic run(input int pulse_at, input int rst_at, output int lat, output int ndone);
      @(negedge clk);
      req   = 1'b1;
      lat   = -1;
      ndone = 0;
      for (int n = 1; n <= 16; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            ndone++;
            if (lat < 0) lat = n;
         end
         @(negedge clk);
         req       = (n == pulse_at) || (pulse_at > 0 && done);
         gen_reset = (n == rst_at);
      end
      req       = 1'b0;
      gen_reset = 1'b0;
   endtask

   int lat, nd;
   int lat_exp_037;

   initial begin
      for (int j = 0; j < 16; j++) mem[j] = '0;
      gen_reset = 1'b1;
      req       = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      gen_reset = 1'b0;
      chk("rst busy",       busy,          0);
      chk("rst done",       done,          0);
      chk("rst count_read", count_read,    0);
      chk("rst adress",     adress,        0);
      chk("rst victim_a",   victim_adress, 0);
      chk("rst victim_c",   victim_count,  0);

      // Basic search
      load(32'h8649_3735);
      run(0, 0, lat, nd);
      chk("basic latency", lat, 10);
      chk("basic ndone",   nd,  1);
      chk("basic victim_a", victim_adress, 1);
      chk("basic victim_c", victim_count,  3);

      // All counts at maximum
      load(32'hFFFF_FFFF);
      run(0, 0, lat, nd);
      chk("allmax latency",  lat, 10);
      chk("allmax victim_a", victim_adress, 0);
      chk("allmax victim_c", victim_count,  15);

      // req while busy and in the done cycle
      load(32'h8649_3735);
      run(4, 0, lat, nd);
      chk("rereq latency",  lat, 10);
      chk("rereq ndone",    nd,  1);
      chk("rereq victim_a", victim_adress, 1);
      chk("rereq victim_c", victim_count,  3);
      chk("rereq idle",     busy, 0);

      // Tie goes to the lower address
      load(32'h8765_1122);
      run(0, 0, lat, nd);
      chk("tie victim_a", victim_adress, 2);
      chk("tie victim_c", victim_count,  1);

      // Reset mid-scan
      load(32'h8649_3735);
      run(0, 5, lat, nd);
      chk("abort ndone",    nd, 0);
      chk("abort busy",     busy, 0);
      chk("abort victim_a", victim_adress, 0);
      chk("abort victim_c", victim_count,  0);

      // Zero count
`ifdef LFU_EARLY_EXIT_EN
      lat_exp_037 = 5;
`else
      lat_exp_037 = 10;
`endif
      load(32'h9999_2035);
      run(0, 0, lat, nd);
      chk("zero latency",  lat, lat_exp_037);
      chk("zero victim_a", victim_adress, 2);
      chk("zero victim_c", victim_count,  0);

      // Zero in the last entry
      load(32'h0333_3333);
      run(0, 0, lat, nd);
      chk("zlast latency",  lat, 10);
      chk("zlast victim_a", victim_adress, 7);
      chk("zlast victim_c", victim_count,  0);

      // Reset dominates req
      @(negedge clk);
      req       = 1'b1;
      gen_reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rstdom busy",       busy,       0);
      chk("rstdom count_read", count_read, 0);
      @(negedge clk);
      req       = 1'b0;
      gen_reset = 1'b0;

      // Random counts, checked by the model
      for (int r = 0; r < 6; r++) begin
         load($urandom());
         run(0, 0, lat, nd);
         chk("rand ndone", nd, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule
